// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// data width and baud-timing helpers.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_e;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_baud_cnt_w(input int unsigned clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO; writes while full are dropped, the head entry is
// visible on rd_data_o whenever empty_o is low.
module uart_byte_fifo import uart_pkg::*; #(
  parameter int unsigned WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push      = wr_i & ~full_o;
  assign pop       = rd_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Buffered 8N1 UART transmitter fed by a write-strobe byte stream.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_ctrl #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned BAUD_RATE       = 115_200,
  parameter int unsigned UART_DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [UART_DATA_WIDTH-1:0] data_byte,
  input  logic                       we,
  output logic                       tx,
  output logic                       busy,
  output logic                       full,
  output logic                       overflow
);

  import uart_pkg::*;

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W        = calc_baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(UART_DATA_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_ctrl: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 8) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_ctrl: FIFO_DEPTH must be a power of 2 and at least 8");
  end
  if (UART_DATA_WIDTH != uart_pkg::UART_DATA_WIDTH) begin : g_bad_width
    $error("uart_tx_ctrl: UART_DATA_WIDTH must be 8");
  end

  uart_tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 idx_q, idx_d;
  logic [UART_DATA_WIDTH-1:0] sh_q, sh_d;
  logic                       tx_q, tx_d;
  logic                       ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic                       par_q, par_d;
`endif

  logic                       load;
  logic                       bit_end;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic [UART_DATA_WIDTH-1:0] fifo_head;

  uart_byte_fifo #(
    .WIDTH (UART_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_i      (we),
    .wr_data_i (data_byte),
    .rd_i      (load),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bit_end  = (cnt_q == '0);
  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE) | ~fifo_empty;
  assign full     = fifo_full;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if ((state_q != ST_IDLE) && !bit_end) cnt_d = cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        load = ~fifo_empty;
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
          cnt_d   = BIT_LAST;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = BIT_LAST;
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          cnt_d   = BIT_LAST;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // IDLE and end-of-STOP share one frame-launch path so back-to-back frames have no gap.
    if (load) begin
      sh_d    = fifo_head;
      tx_d    = 1'b0;
      cnt_d   = BIT_LAST;
      idx_d   = '0;
      state_d = ST_START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_head;
`endif
    end
  end

  assign ovf_d = ovf_q | (we & fifo_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: line monitor + byte scoreboard,
// table-driven single frames and hand-written multi-cycle sequences.
module tb_uart_tx_ctrl;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  localparam int unsigned F = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_byte = 8'h00;
  logic       we = 1'b0;
  logic       tx, busy, full, overflow;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  logic [7:0]  exp_q[$];
  int unsigned starts_q[$];

  typedef struct {
    logic [7:0] data;
    logic       exp_lsb;
    logic       exp_par;
  } vec_t;
  vec_t vecs [7];

  uart_tx_ctrl #(
    .CLK_FREQ        (400),
    .BAUD_RATE       (100),
    .UART_DATA_WIDTH (8),
    .FIFO_DEPTH      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_byte (data_byte),
    .we        (we),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .overflow  (overflow)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then move to the sampling point.
  task automatic cyc_drive(input logic w, input logic [7:0] d, input bit acc);
    @(posedge clk);
    #1;
    we = w;
    data_byte = d;
    if (w && acc) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check1("idle_timeout", busy, 1'b0);
  endtask

  // Line monitor: decodes frames sample by sample and scores them against exp_q.
  initial begin
    bit          mon_act = 0;
    bit          mon_err = 0;
    int unsigned mon_s = 0;
    int unsigned b;
    logic        mon_lvl = 1'b1;
    logic [7:0]  mon_byte = 8'h00;
    logic [7:0]  exp_b;
`ifdef UART_TX_PARITY_EN
    logic        mon_par = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_act = 0;
      end else if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1;
          mon_s   = 1;
          mon_err = 0;
          mon_lvl = 1'b0;
          starts_q.push_back(cyc);
        end
      end else begin
        b = mon_s / CPB;
        if (mon_s % CPB == 0) begin
          mon_lvl = tx;
          if (b >= 1 && b <= 8) mon_byte[3'(b - 1)] = tx;
`ifdef UART_TX_PARITY_EN
          if (b == 9) mon_par = tx;
`endif
        end else if (tx !== mon_lvl) begin
          mon_err = 1;
        end
        if (b == 0 && tx !== 1'b0) mon_err = 1;
        if (b == NB - 1 && tx !== 1'b1) mon_err = 1;
        if (mon_s == F - 1) begin
          mon_act = 0;
          check1("frame_format", mon_err, 1'b0);
          checkn("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checkn("frame_byte", int'(mon_byte), int'(exp_b));
`ifdef UART_TX_PARITY_EN
            check1("frame_parity", mon_par, ^exp_b);
`endif
          end
        end else begin
          mon_s++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lows;
    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b1};
    vecs[5] = '{8'h07, 1'b1, 1'b1};
    vecs[6] = '{8'h03, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check1("rst_tx", tx, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_full", full, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames from the vector table
    for (int unsigned i = 0; i < 7; i++) begin
      int unsigned at;
      cyc_drive(1'b1, vecs[i].data, 1'b1);
      check1("vec_busy_N", busy, 1'b0);
      cyc_drive(1'b0, 8'h00, 1'b0);
      check1("vec_tx_N1", tx, 1'b1);
      check1("vec_busy_N1", busy, 1'b1);
      cyc_drive(1'b0, 8'h00, 1'b0);
      check1("vec_start_N2", tx, 1'b0);
      repeat (4) cyc_drive(1'b0, 8'h00, 1'b0);
      check1("vec_lsb", tx, vecs[i].exp_lsb);
      at = 6;
`ifdef UART_TX_PARITY_EN
      repeat (32) cyc_drive(1'b0, 8'h00, 1'b0);
      check1("vec_parity_bit", tx, vecs[i].exp_par);
      at = 38;
`endif
      repeat (F + 1 - at) cyc_drive(1'b0, 8'h00, 1'b0);
      check1("vec_busy_last_stop", busy, 1'b1);
      check1("vec_tx_last_stop", tx, 1'b1);
      cyc_drive(1'b0, 8'h00, 1'b0);
      check1("vec_busy_fall", busy, 1'b0);
      check1("vec_tx_idle", tx, 1'b1);
    end

    // Burst of 6: back-to-back frames, in order
    starts_q.delete();
    for (int unsigned i = 0; i < 6; i++) cyc_drive(1'b1, 8'(i + 1), 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b0);
    wait_idle(6 * F + 20);
    checkn("burst_frames", starts_q.size(), 6);
    for (int unsigned i = 1; i < 6 && i < starts_q.size(); i++)
      checkn("burst_spacing", int'(starts_q[i] - starts_q[i-1]), int'(F));
    checkn("burst_drained", exp_q.size(), 0);

    // Overflow: 20 writes, bytes 17..19 dropped
    for (int unsigned i = 0; i < 20; i++) begin
      cyc_drive(1'b1, 8'(8'h40 + i), i <= 16);
      if (i == 16) check1("ovf_full_c16", full, 1'b0);
      if (i == 17) begin
        check1("ovf_full_c17", full, 1'b1);
        check1("ovf_flag_c17", overflow, 1'b0);
      end
      if (i == 18) check1("ovf_flag_c18", overflow, 1'b1);
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
    wait_idle(17 * F + 40);
    check1("ovf_sticky", overflow, 1'b1);
    checkn("ovf_drained", exp_q.size(), 0);

    // Reset during DATA bit 3 with two bytes queued
    for (int unsigned i = 0; i < 18; i++) begin
      logic [7:0] bv;
      bv = (i == 0) ? 8'h35 : (i == 1) ? 8'h5A : 8'h96;
      cyc_drive(i < 3, bv, 1'b1);
    end
    @(posedge clk);
    #2;
    check1("mid_bit3_low", tx, 1'b0);
    rst = 1'b1;
    #1;
    check1("mid_rst_tx", tx, 1'b1);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lows = 0;
    repeat (60) begin
      cyc_drive(1'b0, 8'h00, 1'b0);
      if (tx !== 1'b1) lows++;
    end
    checkn("post_rst_quiet", lows, 0);
    check1("post_rst_busy", busy, 1'b0);
    cyc_drive(1'b1, 8'hC3, 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b0);
    wait_idle(F + 20);
    checkn("post_rst_frame", exp_q.size(), 0);

    // Write while full coinciding with the STOP->START pop
    for (int unsigned i = 0; i <= F + 2; i++) begin
      logic w;
      w = (i <= 16) || (i == F + 1) || (i == F + 2);
      cyc_drive(w, 8'(8'h80 + i), i != F + 1);
      if (i == F + 1) begin
        check1("fp_full_at_pop", full, 1'b1);
        check1("fp_ovf_before", overflow, 1'b0);
      end
      if (i == F + 2) begin
        check1("fp_full_after", full, 1'b0);
        check1("fp_ovf_after", overflow, 1'b1);
      end
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
    check1("fp_refill_full", full, 1'b1);
    wait_idle(18 * F + 40);
    checkn("fp_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
